// File: rtl/data_sram_like_resp_pkg.sv
// data_sram_like_resp_pkg: shared encodings, pending-entry layout and strobe merge helper
package data_sram_like_resp_pkg;
    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;
    localparam int SRAM_LIKE_RESP_ENTRY_WD = 33;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_entry_t;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                                 input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction
endpackage

// File: rtl/data_sram_like_resp_fifo.sv
// data_sram_like_resp_fifo: in-order pending queue with a per-entry response countdown
module data_sram_like_resp_fifo
    import data_sram_like_resp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  resp_entry_t push_entry_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic        head_ready_o,
    output resp_entry_t head_entry_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DELAY + 1);

    resp_entry_t      entry_q [DEPTH];
    logic [CW-1:0]    cnt_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    assign full_o       = count_q == (PW+1)'(DEPTH);
    assign empty_o      = count_q == '0;
    assign head_ready_o = valid_q[rd_ptr_q] && cnt_q[rd_ptr_q] == '0;
    assign head_entry_o = entry_q[rd_ptr_q];

    // countdown every waiting entry; a fresh entry starts at DELAY-1 so the head is ready DELAY cycles after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (valid_q[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                cnt_q[wr_ptr_q]   <= CW'(DELAY - 1);
                entry_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/data_sram_like_resp.sv
// data_sram_like_resp: SRAM-like data responder with internal RAM; RESP_RANDOM_DELAY_EN adds LFSR stalls
module data_sram_like_resp
    import data_sram_like_resp_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DELAY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    logic [31:0]       ram_q [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] idx;
    logic              accept, full, empty, head_ready, addr_gate, pop_gate;
    resp_entry_t       push_entry, head_entry;
    logic              unused_ok;

`ifdef RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    // maximal-length Fibonacci LFSR driving random accept/response stalls
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // LFSR state, reseeded on reset so stall patterns are reproducible
    always_ff @(posedge clk) lfsr_q <= reset ? 16'hACE1 : lfsr_d;
    assign addr_gate = lfsr_q[0];
    assign pop_gate  = lfsr_q[3];
`else
    assign addr_gate = 1'b1;
    assign pop_gate  = 1'b1;
`endif

    assign idx               = data_sram_addr[ADDR_W+1:2];
    assign data_sram_addr_ok = !reset && !full && addr_gate;
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign data_sram_data_ok = !reset && head_ready && pop_gate;
    assign data_sram_rdata   = (data_sram_data_ok && !head_entry.wr) ? head_entry.rdata : 32'h0;
    assign push_entry        = '{wr: data_sram_wr, rdata: data_sram_wr ? 32'h0 : ram_q[idx]};
    assign unused_ok         = &{1'b0, data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0], empty};

    // writes commit at accept so a later read of the same word sees the merged data
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) ram_q[idx] <= strobe_merge(ram_q[idx], data_sram_wdata, data_sram_wstrb);
    end

    data_sram_like_resp_fifo #(.DEPTH(MAX_OUTSTANDING), .DELAY(RESP_DELAY)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_entry_i(push_entry),
        .pop_i       (data_sram_data_ok),
        .full_o      (full),
        .empty_o     (empty),
        .head_ready_o(head_ready),
        .head_entry_o(head_entry)
    );
endmodule

// File: tb/tb_data_sram_like_resp.sv
// tb_data_sram_like_resp: scoreboard bench for the SRAM-like responder (fast and slow instances)
module tb_data_sram_like_resp;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  size = 2'd2;
    logic        req = 1'b0, wr = 1'b0, s_req = 1'b0, s_wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, s_addr = '0, s_wdata = '0;
    logic [3:0]  wstrb = '0, s_wstrb = '0;
    logic        addr_ok, data_ok, s_addr_ok, s_data_ok;
    logic [31:0] rdata, s_rdata;
    int          tests = 0, fails = 0, cyc = 0, bad_idle = 0, stuck = 0;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } ev_t;
    ev_t         exp_q[$], got_q[$];
    logic [31:0] mem [int];

    always #5 clk = ~clk;

    data_sram_like_resp #(.ADDR_W(10), .MAX_OUTSTANDING(4), .RESP_DELAY(2)) u_dut (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
    );

    data_sram_like_resp #(.ADDR_W(10), .MAX_OUTSTANDING(4), .RESP_DELAY(6)) u_slow (
        .clk(clk), .reset(reset), .data_sram_req(s_req), .data_sram_wr(s_wr), .data_sram_size(size),
        .data_sram_addr(s_addr), .data_sram_wstrb(s_wstrb), .data_sram_wdata(s_wdata),
        .data_sram_addr_ok(s_addr_ok), .data_sram_data_ok(s_data_ok), .data_sram_rdata(s_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // reference model of the fast instance: expected pushed at accept, observed pushed at data_ok
    always @(negedge clk) begin
        ev_t         e;
        logic [31:0] w;
        int          idx;
        if (reset) begin
            if (addr_ok || data_ok || rdata != 32'h0) bad_idle = bad_idle + 1;
            exp_q.delete();
            got_q.delete();
        end else begin
            if (data_ok) begin
                e.rdata = rdata;
                e.cyc   = cyc;
                got_q.push_back(e);
            end else if (rdata != 32'h0) bad_idle = bad_idle + 1;
            if (req && addr_ok) begin
                idx = int'(addr[11:2]);
                w   = mem.exists(idx) ? mem[idx] : 32'h0;
                if (wr) begin
                    for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    mem[idx] = w;
                    e.rdata  = 32'h0;
                end else e.rdata = w;
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok    = 1'b0;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = addr_ok;
            @(posedge clk);
            #1;
        end
        if (!ok) stuck++;
        req = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            tests++; if (addr_ok !== 1'b0) begin fails++; $display("FAIL reset_addr_ok: got %b want 0", addr_ok); end
            tests++; if (data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
            tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
            tests++; if (s_addr_ok !== 1'b0) begin fails++; $display("FAIL reset_slow_addr_ok: got %b want 0", s_addr_ok); end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++; if (data_ok !== 1'b0) begin fails++; $display("FAIL post_reset_data_ok: got %b want 0", data_ok); end
`ifndef RESP_RANDOM_DELAY_EN
        tests++; if (addr_ok !== 1'b1) begin fails++; $display("FAIL post_reset_addr_ok: got %b want 1", addr_ok); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        ev_t g, e;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_drain(1);
        tests++;
        if (got_q.size() !== 1 || exp_q.size() !== 1) begin
            fails++; $display("FAIL write_count: got %0d responses want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests++; if (g.rdata !== 32'h0) begin fails++; $display("FAIL write_rdata: got %h want 0", g.rdata); end
`ifndef RESP_RANDOM_DELAY_EN
            tests++; if (g.cyc !== e.cyc + 2) begin fails++; $display("FAIL write_latency: got %0d want %0d", g.cyc - e.cyc, 2); end
`endif
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_partial();
        ev_t g0, g1, e0, e1;
        issue(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_drain(2);
        tests++;
        if (got_q.size() !== 2 || exp_q.size() !== 2) begin
            fails++; $display("FAIL partial_count: got %0d responses want 2", got_q.size());
        end else begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            tests++; if (g0.rdata !== 32'h0) begin fails++; $display("FAIL partial_wr_rdata: got %h want 0", g0.rdata); end
            tests++; if (g1.rdata !== 32'hDEADABEF) begin fails++; $display("FAIL partial_rd_rdata: got %h want deadabef", g1.rdata); end
`ifndef RESP_RANDOM_DELAY_EN
            tests++; if (g1.cyc !== g0.cyc + 1) begin fails++; $display("FAIL partial_gap: got %0d want 1", g1.cyc - g0.cyc); end
            tests++; if (g1.cyc !== e1.cyc + 2) begin fails++; $display("FAIL partial_latency: got %0d want 2", g1.cyc - e1.cyc); end
`endif
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t g, e;
        int  prev;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'(4 * i), 32'(i + 1), 4'hF);
        wait_drain(3);
        tests++; if (got_q.size() !== 3) begin fails++; $display("FAIL b2b_preload_count: got %0d want 3", got_q.size()); end
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) issue(1'b0, 32'(4 * i), 32'h0, 4'h0);
        wait_drain(3);
        tests++;
        if (got_q.size() !== 3 || exp_q.size() !== 3) begin
            fails++; $display("FAIL b2b_count: got %0d responses want 3", got_q.size());
        end else begin
            prev = 0;
            for (int i = 0; i < 3; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                tests++; if (g.rdata !== 32'(i + 1)) begin fails++; $display("FAIL b2b_rdata%0d: got %h want %h", i, g.rdata, 32'(i + 1)); end
`ifndef RESP_RANDOM_DELAY_EN
                tests++; if (g.cyc !== e.cyc + 2) begin fails++; $display("FAIL b2b_latency%0d: got %0d want 2", i, g.cyc - e.cyc); end
                if (i > 0) begin
                    tests++; if (g.cyc !== prev + 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 1", i, g.cyc - prev); end
                end
`endif
                prev = g.cyc;
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full();
        int          k, n;
        int          acc[$], rsp[$];
        logic [31:0] rd[$];
        int          accw[8] = '{0, 1, 2, 3, 7, 8, 9, 10};
        int          rspw[8] = '{6, 7, 8, 9, 13, 14, 15, 16};
        k = 0;
        n = 0;
        for (int i = 0; i < 200 && n < 8; i++) begin
            s_req = k < 8; s_wr = 1'b1; s_addr = 32'(4 * k); s_wdata = 32'h100 + 32'(k); s_wstrb = 4'hF;
            @(negedge clk);
            if (s_data_ok) n++;
            if (s_req && s_addr_ok) k++;
            @(posedge clk);
            #1;
        end
        s_req = 1'b0;
        tests++; if (n !== 8) begin fails++; $display("FAIL full_preload: got %0d want 8", n); end
        k = 0;
        for (int i = 0; i < 40; i++) begin
            s_req = k < 8; s_wr = 1'b0; s_addr = 32'(4 * k);
            @(negedge clk);
`ifndef RESP_RANDOM_DELAY_EN
            if (i == 4) begin
                tests++; if (s_addr_ok !== 1'b0) begin fails++; $display("FAIL full_addr_ok_drop: got %b want 0", s_addr_ok); end
            end
            if (i == 7) begin
                tests++; if (s_addr_ok !== 1'b1) begin fails++; $display("FAIL full_addr_ok_resume: got %b want 1", s_addr_ok); end
            end
`endif
            if (s_data_ok) begin rsp.push_back(i); rd.push_back(s_rdata); end
            if (s_req && s_addr_ok) begin acc.push_back(i); k++; end
            @(posedge clk);
            #1;
        end
        s_req = 1'b0;
        tests++;
        if (rd.size() !== 8 || acc.size() !== 8) begin
            fails++; $display("FAIL full_count: got %0d responses want 8", rd.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                tests++; if (rd[j] !== 32'h100 + 32'(j)) begin fails++; $display("FAIL full_order%0d: got %h want %h", j, rd[j], 32'h100 + 32'(j)); end
`ifndef RESP_RANDOM_DELAY_EN
                tests++; if (acc[j] !== accw[j]) begin fails++; $display("FAIL full_accept%0d: got %0d want %0d", j, acc[j], accw[j]); end
                tests++; if (rsp[j] !== rspw[j]) begin fails++; $display("FAIL full_resp%0d: got %0d want %0d", j, rsp[j], rspw[j]); end
`endif
            end
        end
    endtask

    task automatic test_reset_drop();
        int          n, at;
        logic [31:0] rv;
        n = 0;
        for (int i = 0; i < 22; i++) begin
            s_req = i < 3; s_wr = 1'b0; s_addr = 32'(4 * i);
            reset = i == 5;
            @(negedge clk);
            if (i == 5) begin
                tests++; if (s_addr_ok !== 1'b0) begin fails++; $display("FAIL drop_reset_addr_ok: got %b want 0", s_addr_ok); end
            end
            if (s_data_ok) n++;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        s_req = 1'b0;
        tests++; if (n !== 0) begin fails++; $display("FAIL drop_stale_resp: got %0d responses want 0", n); end
        at = -1;
        rv = 32'h0;
        for (int j = 0; j < 20; j++) begin
            s_req = j == 0; s_addr = 32'h1C;
            @(negedge clk);
`ifndef RESP_RANDOM_DELAY_EN
            if (j == 0) begin
                tests++; if (s_addr_ok !== 1'b1) begin fails++; $display("FAIL drop_accept: got %b want 1", s_addr_ok); end
            end
`endif
            if (s_data_ok && at < 0) begin at = j; rv = s_rdata; end
            @(posedge clk);
            #1;
        end
        s_req = 1'b0;
        tests++; if (rv !== 32'h107) begin fails++; $display("FAIL drop_next_rdata: got %h want 00000107", rv); end
`ifndef RESP_RANDOM_DELAY_EN
        tests++; if (at !== 6) begin fails++; $display("FAIL drop_next_latency: got %0d want 6", at); end
`endif
    endtask

    task automatic test_random();
        ev_t g, e;
        int  n;
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 1000; i++) begin
            issue(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain(1016);
        tests++;
        if (got_q.size() !== 1016 || exp_q.size() !== 1016) begin
            fails++; $display("FAIL random_count: got %0d responses for %0d accepts want 1016", got_q.size(), exp_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            tests++; if (g.rdata !== e.rdata) begin fails++; $display("FAIL random_rdata%0d: got %h want %h", n, g.rdata, e.rdata); end
`ifndef RESP_RANDOM_DELAY_EN
            tests++; if (g.cyc !== e.cyc + 2) begin fails++; $display("FAIL random_latency%0d: got %0d want 2", n, g.cyc - e.cyc); end
`endif
            n++;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_partial();
        test_back_to_back();
        test_full();
        test_reset_drop();
        test_random();
        tests++; if (bad_idle !== 0) begin fails++; $display("FAIL idle_outputs: got %0d bad cycles want 0", bad_idle); end
        tests++; if (stuck !== 0) begin fails++; $display("FAIL accept_timeout: got %0d stuck requests want 0", stuck); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
